// File: rtl/m216a_dsm_pkg.sv
// m216a_dsm_pkg
//   Definitions shared by the MASH 1-1-1 decimator and M216A_TopModule.
//   DSM_OUT_W      : width of one modulator output sample
//   FRAC_W         : width of the fractional part of the decimated mean
//   LOG2_N_DEFAULT : default log2 of the averaging window length
//   dec_state_t    : decimator control FSM states (WARMUP, RUN)
package m216a_dsm_pkg;

  localparam int unsigned DSM_OUT_W      = 4;
  localparam int unsigned FRAC_W         = 16;
  localparam int unsigned LOG2_N_DEFAULT = 16;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } dec_state_t;

endpackage : m216a_dsm_pkg

// File: rtl/m216a_dec_window_cnt.sv
// m216a_dec_window_cnt
//   Counts accepted samples of one averaging window (0..2^LOG2_N-1).
//   Parameters:
//     LOG2_N : log2 of the window length
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset, counter to 0
//     clr  : synchronous window restart, counter to 0 (wins over inc)
//     inc  : one sample accepted this cycle
//     last : high when the sample accepted this cycle completes the window
module m216a_dec_window_cnt
  import m216a_dsm_pkg::*;
#(
  parameter int unsigned LOG2_N = LOG2_N_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [LOG2_N-1:0] count;

  // The counter wraps from N-1 to 0 by natural overflow, so the next window
  // starts on the very next accepted sample.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign last = inc && (count == '1);

endmodule : m216a_dec_window_cnt

// File: rtl/m216a_dsm_decimator.sv
// m216a_dsm_decimator
//   Boxcar decimator for a MASH 1-1-1 modulator output: averages N = 2^LOG2_N
//   accepted samples and presents the mean as integer + 16-bit fraction.
//   Parameters:
//     LOG2_N    : log2 of the window length, legal 4..16
//   Ports:
//     clk       : clock, rising edge
//     rst       : synchronous active-high reset (priority over clr/din_valid)
//     din       : 4-bit unsigned modulator sample
//     din_valid : din accepted this cycle
//     clr       : synchronous window restart, discards any sample this cycle
//     avg_i     : integer part of the window mean
//     avg_f     : fractional part of the window mean, units of 1/65536
//     avg_valid : one-cycle pulse marking new avg_i/avg_f
//   Build option:
//     M216A_DEC_WARMUP_EN : when defined, the first completed window after
//                           reset is discarded to flush modulator pipeline fill
module m216a_dsm_decimator
  import m216a_dsm_pkg::*;
#(
  parameter int unsigned LOG2_N = LOG2_N_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DSM_OUT_W-1:0] din,
  input  logic                 din_valid,
  input  logic                 clr,
  output logic [DSM_OUT_W-1:0] avg_i,
  output logic [FRAC_W-1:0]    avg_f,
  output logic                 avg_valid
);

  localparam int unsigned SUM_W = DSM_OUT_W + LOG2_N;

  dec_state_t       state;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_acc;
  logic [FRAC_W-1:0] frac_aligned;
  logic             accept;
  logic             last;
  logic             publish;

  // clr drops the sample presented with it, so it never reaches the counter.
  assign accept = din_valid && !clr;

  m216a_dec_window_cnt #(
    .LOG2_N (LOG2_N)
  ) u_window_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (accept),
    .last (last)
  );

  // Sum including the current sample; 15*N < 16*N so SUM_W never overflows.
  assign sum_acc = sum + SUM_W'(din);

  // Left-align the LOG2_N fraction bits into FRAC_W with zero fill.
  always_comb begin
    frac_aligned = '0;
    frac_aligned = FRAC_W'(sum_acc[LOG2_N-1:0]) << (FRAC_W - LOG2_N);
  end

`ifdef M216A_DEC_WARMUP_EN
  assign publish = (state == RUN);
`else
  assign publish = (state == RUN) || (state == WARMUP);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      avg_i     <= '0;
      avg_f     <= '0;
      avg_valid <= 1'b0;
      state     <= WARMUP;
    end else begin
      avg_valid <= 1'b0;
      if (clr) begin
        sum <= '0;
      end else if (din_valid) begin
        if (last) begin
          sum   <= '0;
          state <= RUN;
          if (publish) begin
            avg_i     <= sum_acc[SUM_W-1:LOG2_N];
            avg_f     <= frac_aligned;
            avg_valid <= 1'b1;
          end
        end else begin
          sum <= sum_acc;
        end
      end
    end
  end

endmodule : m216a_dsm_decimator

// File: tb/tb_m216a_dsm_decimator.sv
module tb_m216a_dsm_decimator;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  din;
  logic        din_valid;
  logic        clr;
  logic [3:0]  avg_i;
  logic [15:0] avg_f;
  logic        avg_valid;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  m216a_dsm_decimator #(
    .LOG2_N (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clr       (clr),
    .avg_i     (avg_i),
    .avg_f     (avg_f),
    .avg_valid (avg_valid)
  );

  // Apply inputs for one clock edge; outputs are sampled 1 time unit after it.
  task automatic cyc(input logic [3:0] d, input logic dv, input logic c, input logic r);
    din       = d;
    din_valid = dv;
    clr       = c;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(4'd7, 1'b1, 1'b1, 1'b1);
    cyc(4'd7, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (avg_i !== 4'd0) begin n_fail++; $display("FAIL reset_avg_i got %0d want 0", avg_i); end
    n_checks++;
    if (avg_f !== 16'h0000) begin n_fail++; $display("FAIL reset_avg_f got %h want 0000", avg_f); end
    n_checks++;
    if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_avg_valid got %b want 0", avg_valid); end
  endtask

  // Two back-to-back windows: 16 x 8 then 16 x 3, no idle cycle between.
  task automatic test_constant();
    for (int i = 0; i < 16; i++) begin
      cyc(4'd8, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (avg_valid !== (i == 15)) begin
        n_fail++; $display("FAIL const8_valid[%0d] got %b want %b", i, avg_valid, (i == 15));
      end
    end
    n_checks++;
    if (avg_i !== 4'd8) begin n_fail++; $display("FAIL const8_avg_i got %0d want 8", avg_i); end
    n_checks++;
    if (avg_f !== 16'h0000) begin n_fail++; $display("FAIL const8_avg_f got %h want 0000", avg_f); end
    for (int i = 0; i < 16; i++) begin
      cyc(4'd3, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (avg_valid !== (i == 15)) begin
        n_fail++; $display("FAIL b2b3_valid[%0d] got %b want %b", i, avg_valid, (i == 15));
      end
      if (i < 15) begin
        n_checks++;
        if (avg_i !== 4'd8) begin n_fail++; $display("FAIL hold_avg_i[%0d] got %0d want 8", i, avg_i); end
      end
    end
    n_checks++;
    if (avg_i !== 4'd3) begin n_fail++; $display("FAIL b2b3_avg_i got %0d want 3", avg_i); end
  endtask

  // 8,9 alternating: sum = 136 = 0x88 -> avg_i 8, avg_f 0x8000.
  task automatic test_alternating();
    for (int i = 0; i < 16; i++) begin
      cyc((i % 2 == 0) ? 4'd8 : 4'd9, 1'b1, 1'b0, 1'b0);
    end
    n_checks++;
    if (avg_valid !== 1'b1) begin n_fail++; $display("FAIL alt_valid got %b want 1", avg_valid); end
    n_checks++;
    if (avg_i !== 4'd8) begin n_fail++; $display("FAIL alt_avg_i got %0d want 8", avg_i); end
    n_checks++;
    if (avg_f !== 16'h8000) begin n_fail++; $display("FAIL alt_avg_f got %h want 8000", avg_f); end
  endtask

  // 15 x 1 then one 4: sum = 19 = 0x13 -> avg_i 1, avg_f 0x3000.
  task automatic test_fraction();
    for (int i = 0; i < 16; i++) begin
      cyc((i == 15) ? 4'd4 : 4'd1, 1'b1, 1'b0, 1'b0);
    end
    n_checks++;
    if (avg_valid !== 1'b1) begin n_fail++; $display("FAIL frac_valid got %b want 1", avg_valid); end
    n_checks++;
    if (avg_i !== 4'd1) begin n_fail++; $display("FAIL frac_avg_i got %0d want 1", avg_i); end
    n_checks++;
    if (avg_f !== 16'h3000) begin n_fail++; $display("FAIL frac_avg_f got %h want 3000", avg_f); end
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL frac_pulse_width got %b want 0", avg_valid); end
  endtask

  // din_valid toggles; invalid cycles carry 15 which must be ignored.
  task automatic test_gaps();
    for (int i = 0; i < 32; i++) begin
      cyc((i % 2 == 0) ? 4'd5 : 4'd15, (i % 2 == 0), 1'b0, 1'b0);
      n_checks++;
      if (avg_valid !== (i == 30)) begin
        n_fail++; $display("FAIL gaps_valid[%0d] got %b want %b", i, avg_valid, (i == 30));
      end
    end
    n_checks++;
    if (avg_i !== 4'd5) begin n_fail++; $display("FAIL gaps_avg_i got %0d want 5", avg_i); end
    n_checks++;
    if (avg_f !== 16'h0000) begin n_fail++; $display("FAIL gaps_avg_f got %h want 0000", avg_f); end
  endtask

  // clr with din_valid after 7 samples: sample dropped, window restarts.
  task automatic test_clr();
    for (int i = 0; i < 7; i++) cyc(4'd1, 1'b1, 1'b0, 1'b0);
    cyc(4'd15, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got %b want 0", avg_valid); end
    n_checks++;
    if (avg_i !== 4'd5) begin n_fail++; $display("FAIL clr_hold_avg_i got %0d want 5", avg_i); end
    for (int i = 0; i < 16; i++) begin
      cyc(4'd2, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (avg_valid !== (i == 15)) begin
        n_fail++; $display("FAIL clr_valid[%0d] got %b want %b", i, avg_valid, (i == 15));
      end
    end
    n_checks++;
    if (avg_i !== 4'd2) begin n_fail++; $display("FAIL clr_avg_i got %0d want 2", avg_i); end
    n_checks++;
    if (avg_f !== 16'h0000) begin n_fail++; $display("FAIL clr_avg_f got %h want 0000", avg_f); end
  endtask

  // rst mid-window (with din_valid and clr also high): partial window lost.
  task automatic test_rst_mid();
    for (int i = 0; i < 5; i++) cyc(4'd9, 1'b1, 1'b0, 1'b0);
    cyc(4'd9, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (avg_i !== 4'd0) begin n_fail++; $display("FAIL rstmid_avg_i got %0d want 0", avg_i); end
    n_checks++;
    if (avg_f !== 16'h0000) begin n_fail++; $display("FAIL rstmid_avg_f got %h want 0000", avg_f); end
    n_checks++;
    if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_avg_valid got %b want 0", avg_valid); end
    for (int i = 0; i < 16; i++) begin
      cyc(4'd6, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (avg_valid !== (i == 15)) begin
        n_fail++; $display("FAIL rstmid_valid[%0d] got %b want %b", i, avg_valid, (i == 15));
      end
    end
    n_checks++;
    if (avg_i !== 4'd6) begin n_fail++; $display("FAIL rstmid_avg_i_after got %0d want 6", avg_i); end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; din = '0; din_valid = 1'b0;
    test_reset();
    test_constant();
    test_alternating();
    test_fraction();
    test_gaps();
    test_clr();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_m216a_dsm_decimator

// File: doc/m216a_dsm_decimator.md
M216A_DSM_DECIMATOR -- requirements
Module: m216a_dsm_decimator

Interface
REQ-001 The parameter LOG2_N SHALL have default 16 and set the averaging window to N = 2^LOG2_N accepted samples, with a legal range of 4..16.
REQ-002 Port clk SHALL be a 1-bit input: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be a 1-bit input: synchronous, active-high reset.
REQ-004 Port din SHALL be a 4-bit unsigned input: one MASH 1-1-1 modulator output sample.
REQ-005 Port din_valid SHALL be a 1-bit input: when high, din is accepted this cycle.
REQ-006 Port clr SHALL be a 1-bit input: synchronous window restart.
REQ-007 Port avg_i SHALL be a 4-bit output: integer part of the window mean.
REQ-008 Port avg_f SHALL be a 16-bit output: fractional part of the window mean in units of 1/65536.
REQ-009 Port avg_valid SHALL be a 1-bit output: a one-cycle pulse marking new avg_i/avg_f.

Function
REQ-010 The block SHALL accumulate accepted samples into a (4+LOG2_N)-bit sum, which cannot overflow because 15*N < 16*N.
REQ-011 A (LOG2_N)-bit counter SHALL count accepted samples (0..N-1).
REQ-012 On the cycle the Nth sample is accepted, the next cycle SHALL show the following, giving 1-cycle latency:
- avg_i = sum[LOG2_N+3:LOG2_N] and avg_f = sum[LOG2_N-1:0] left-aligned to 16 bits with zero fill, where sum includes that sample;
- avg_valid = 1.
REQ-013 On that same cycle the accumulator SHALL clear and the counter SHALL wrap to 0, so the next accepted sample starts a new window with no gap.
REQ-014 avg_i/avg_f SHALL hold their values between pulses.
REQ-015 avg_valid SHALL be high for exactly one cycle per completed window.
REQ-016 When din_valid=0, the sum and counter SHALL be unchanged, and gaps SHALL only stretch the window in time.
REQ-017 When clr=1, the sum and counter SHALL reset to 0 and any sample presented that cycle SHALL be discarded (clr wins over din_valid).
REQ-018 When clr=1, avg_i/avg_f SHALL be unchanged and avg_valid SHALL be 0.
REQ-019 The control FSM SHALL have two states, WARMUP and RUN:
- reset enters WARMUP;
- WARMUP -> RUN at the first window completion;
- RUN persists until rst;
- clr does not change the state.
REQ-020 When M216A_DEC_WARMUP_EN is not defined, WARMUP SHALL behave identically to RUN.

Reset
REQ-021 When rst=1 at a clock edge, the sum, counter, avg_i, avg_f and avg_valid SHALL all be set to 0 and the FSM SHALL enter WARMUP.
REQ-022 rst SHALL take priority over clr and din_valid.
REQ-023 Reset mid-window SHALL discard the partial window with no avg_valid pulse.

Configuration
REQ-024 When macro M216A_DEC_WARMUP_EN is defined, the first completed window after reset SHALL be discarded in WARMUP: no avg_valid pulse and avg_i/avg_f unchanged. This flushes the modulator's pipeline fill.
REQ-025 When M216A_DEC_WARMUP_EN is not defined, every completed window, including the first, SHALL produce a pulse.

Structure
REQ-026 Package m216a_dsm_pkg SHALL hold the following, shared with M216A_TopModule:
- DSM_OUT_W = 4 and FRAC_W = 16;
- LOG2_N_DEFAULT = 16;
- the FSM state typedef (WARMUP, RUN).
REQ-027 The window counter SHALL be a sub-module m216a_dec_window_cnt with inputs clk, rst, clr and inc, and output last (high when count = N-1 and inc=1).

Verification
REQ-028 Constant input: LOG2_N=16, din=8 with din_valid held high, warmup macro off -> the first avg_valid occurs 65536 cycles after the first accepted sample with avg_i=8, avg_f=0, and repeats every 65536 cycles.
REQ-029 End-to-end: din driven by M216A_TopModule with in_i=8, in_f=32000, warmup macro on -> second and later windows give avg_i=8 and avg_f within 32000 +/- 4.
REQ-030 Fraction alignment: LOG2_N=4, din alternating 8,9 -> sum=136, giving avg_i=8 and avg_f=0x8000.
REQ-031 Valid gaps: LOG2_N=4, din_valid toggling every cycle, din=5 -> avg_valid 1 cycle after the 16th accepted sample (about 32 cycles), with avg_i=5 and avg_f=0.
REQ-032 clr collision: LOG2_N=4 with clr=1 and din_valid=1 asserted after 7 samples -> that sample is dropped and the next pulse follows 16 further accepted samples. Asserting rst mid-window instead -> all outputs read 0 on the next cycle and no pulse occurs for the partial window.
